// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Instruction-fetch front end that sits ahead of the IF/ID register. It walks
// sequential word addresses on an instruction memory with variable ack
// latency, buffers returned words together with their PCs in a DEPTH-entry
// FIFO and presents the head entry to the core. A taken branch/jump
// (redirect) flushes the queue and restarts fetching at the target.
//
// All state updates on the falling edge of CLK, the same edge as the core's
// pipeline registers. Rst is synchronous and active-high.
//
// Ports
//   CLK            clock (falling-edge active)
//   Rst            synchronous reset, active-high
//   startPC        fetch PC loaded while Rst=1
//   imem_req       fetch request to instruction memory
//   imem_addr      request address, held while a request is outstanding
//   imem_ack       memory returns imem_data this cycle
//   imem_data      fetched instruction word
//   inst_valid     head entry present
//   inst_data      head instruction
//   inst_pc        head instruction address
//   inst_pc_plus4  inst_pc + 4
//   inst_take      core consumes the head (IF_write)
//   redirect       taken branch/jump: flush and refetch
//   redirect_pc    redirect target
//   count          occupied queue entries
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                       CLK,
  input  logic                       Rst,
  input  logic [ADDR_W-1:0]          startPC,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [DATA_W-1:0]          imem_data,
  output logic                       inst_valid,
  output logic [DATA_W-1:0]          inst_data,
  output logic [ADDR_W-1:0]          inst_pc,
  output logic [ADDR_W-1:0]          inst_pc_plus4,
  input  logic                       inst_take,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

  // FETCH: normal sequential fetching.
  // DISCARD: a redirect arrived while a request was outstanding; the request
  // must complete at its original address and its data is thrown away.
  localparam logic [0:0] ST_FETCH   = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [0:0]        state_r;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] target_r;
  logic              req_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              inst_valid_r;
  logic [DATA_W-1:0] inst_data_r;
  logic [ADDR_W-1:0] inst_pc_r;
  logic [ADDR_W-1:0] inst_pc_plus4_r;

  logic [DATA_W-1:0] data_q_r [DEPTH];
  logic [ADDR_W-1:0] pc_q_r   [DEPTH];

  logic              ack_s;
  logic              pop_s;
  logic              push_s;
  logic [PTR_W-1:0]  rd_nxt_s;
  logic [PTR_W-1:0]  wr_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              head_src_in_s;
  logic [DATA_W-1:0] head_data_nxt_s;
  logic [ADDR_W-1:0] head_pc_nxt_s;

  assign imem_req      = req_r;
  assign imem_addr     = fetch_pc_r;
  assign inst_valid    = inst_valid_r;
  assign inst_data     = inst_data_r;
  assign inst_pc       = inst_pc_r;
  assign inst_pc_plus4 = inst_pc_plus4_r;
  assign count         = count_r;

  // Queue control: push/pop qualification, next pointers/occupancy, next head.
  always_comb begin
    // An ack only counts against a request we actually issued.
    ack_s    = imem_ack & req_r;
    pop_s    = inst_take & (count_r != CNT_ZERO) & ~redirect & ~Rst;
    push_s   = ack_s & (state_r == ST_FETCH) & ~redirect & ~Rst;
    rd_nxt_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    wr_nxt_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;

    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end

    // The incoming word becomes the head when nothing older survives this
    // edge; otherwise the head is the stored entry at the next read pointer.
    head_src_in_s   = push_s & (count_r == (pop_s ? CNT_ONE : CNT_ZERO));
    head_data_nxt_s = head_src_in_s ? imem_data  : data_q_r[rd_nxt_s];
    head_pc_nxt_s   = head_src_in_s ? fetch_pc_r : pc_q_r[rd_nxt_s];
  end

  // Queue storage: word and PC written at the write pointer on a push.
  always_ff @(negedge CLK) begin
    if (push_s) begin
      data_q_r[wr_ptr_r] <= imem_data;
      pc_q_r[wr_ptr_r]   <= fetch_pc_r;
    end
  end

  // Fetch state machine, queue pointers and registered head outputs.
  always_ff @(negedge CLK) begin
    if (Rst) begin
      state_r         <= ST_FETCH;
      fetch_pc_r      <= startPC;
      target_r        <= {ADDR_W{1'b0}};
      req_r           <= 1'b0;
      rd_ptr_r        <= PTR_ZERO;
      wr_ptr_r        <= PTR_ZERO;
      count_r         <= CNT_ZERO;
      inst_valid_r    <= 1'b0;
      inst_data_r     <= {DATA_W{1'b0}};
      inst_pc_r       <= {ADDR_W{1'b0}};
      inst_pc_plus4_r <= {ADDR_W{1'b0}};
    end else if (redirect) begin
      rd_ptr_r     <= PTR_ZERO;
      wr_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      inst_valid_r <= 1'b0;
      req_r        <= 1'b1;
      if (!req_r || imem_ack) begin
        // Nothing left in flight: restart immediately at the target.
        fetch_pc_r <= redirect_pc;
        state_r    <= ST_FETCH;
      end else begin
        // Request still in flight: finish it at the old address first.
        target_r <= redirect_pc;
        state_r  <= ST_DISCARD;
      end
    end else begin
      rd_ptr_r     <= rd_nxt_s;
      wr_ptr_r     <= wr_nxt_s;
      count_r      <= count_nxt_s;
      inst_valid_r <= (count_nxt_s != CNT_ZERO);
      // Request whenever the queue will have room after this edge.
      req_r        <= (count_nxt_s < CNT_FULL);
      if (count_nxt_s != CNT_ZERO) begin
        inst_data_r     <= head_data_nxt_s;
        inst_pc_r       <= head_pc_nxt_s;
        inst_pc_plus4_r <= head_pc_nxt_s + PC_STEP;
      end
      case (state_r)
        ST_FETCH: begin
          if (push_s) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP;
          end
        end
        ST_DISCARD: begin
          if (ack_s) begin
            fetch_pc_r <= target_r;
            state_r    <= ST_FETCH;
          end
        end
        default: begin
          state_r <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

  logic        CLK = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] startPC = 32'h0000_0100;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        inst_take = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  int mem_lat = 0;
  int wcnt = 0;

  instr_prefetch_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) dut (
    .CLK(CLK), .Rst(Rst), .startPC(startPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4),
    .inst_take(inst_take), .redirect(redirect), .redirect_pc(redirect_pc), .count(count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model answers at the rising edge; DUT samples at the falling edge.
  task automatic tick();
    @(posedge CLK);
    if (Rst) begin
      imem_ack = 1'b0; wcnt = 0;
    end else if (imem_req) begin
      if (wcnt >= mem_lat) begin
        imem_ack = 1'b1; imem_data = mem_word(imem_addr); wcnt = 0;
      end else begin
        imem_ack = 1'b0; wcnt++;
      end
    end else begin
      imem_ack = 1'b0; wcnt = 0;
    end
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] spc, input int lat);
    Rst = 1'b1; startPC = spc; mem_lat = lat; inst_take = 1'b0; redirect = 1'b0;
    tick(); tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'h0000_0100, 0);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", inst_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rst_addr got=%h want=100", imem_addr); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", inst_pc); end
    total++; if (inst_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h want=0", inst_pc_plus4); end
    total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", inst_data); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    inst_take = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL stream_first_req got=%b/%h want=1/100", imem_req, imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_valid_early got=%b want=0", inst_valid); end
    tick();
    total++; if (imem_ack !== 1'b1 || inst_valid !== 1'b1) begin bad++; $display("FAIL stream_latency got=ack%b/valid%b want=1/1", imem_ack, inst_valid); end
    total++; if (inst_pc !== 32'h100 || inst_pc_plus4 !== 32'h104) begin bad++; $display("FAIL stream_pc0 got=%h/%h want=100/104", inst_pc, inst_pc_plus4); end
    total++; if (inst_data !== mem_word(32'h100)) begin bad++; $display("FAIL stream_data0 got=%h want=%h", inst_data, mem_word(32'h100)); end
    exp_pc = 32'h100;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      total++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== mem_word(exp_pc)) begin
        bad++; $display("FAIL stream_seq got=%b/%h/%h want=1/%h/%h", inst_valid, inst_pc, inst_data, exp_pc, mem_word(exp_pc));
      end
      total++; if (imem_addr !== exp_pc + 32'd4) begin bad++; $display("FAIL stream_addr got=%h want=%h", imem_addr, exp_pc + 32'd4); end
    end
    inst_take = 1'b0;
  endtask

  task automatic test_fill();
    int acks;
    do_reset(32'h0000_0100, 0);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (imem_ack) acks++;
    end
    total++; if (acks != 4) begin bad++; $display("FAIL fill_acks got=%0d want=4", acks); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", count); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fill_req got=%b want=0", imem_req); end
    total++; if (inst_pc !== 32'h100) begin bad++; $display("FAIL fill_head got=%h want=100", inst_pc); end
    inst_take = 1'b1;
    tick();
    inst_take = 1'b0;
    total++; if (inst_pc !== 32'h104 || count !== 3'd3) begin bad++; $display("FAIL fill_pop got=%h/%0d want=104/3", inst_pc, count); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin bad++; $display("FAIL fill_rereq got=%b/%h want=1/110", imem_req, imem_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    tick();
    total++; if (count !== 3'd4 || imem_req !== 1'b0) begin bad++; $display("FAIL b2b_full got=%0d/%b want=4/0", count, imem_req); end
    inst_take = 1'b1;
    tick();
    total++; if (inst_pc !== 32'h108 || count !== 3'd3 || imem_addr !== 32'h114) begin
      bad++; $display("FAIL b2b_pop got=%h/%0d/%h want=108/3/114", inst_pc, count, imem_addr);
    end
    exp_pc = 32'h108;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      total++; if (imem_ack !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL b2b_count got=ack%b/%0d want=1/3", imem_ack, count); end
      total++; if (inst_pc !== exp_pc || inst_data !== mem_word(exp_pc)) begin bad++; $display("FAIL b2b_seq got=%h/%h want=%h/%h", inst_pc, inst_data, exp_pc, mem_word(exp_pc)); end
    end
    inst_take = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bit found;
    bit got_ack;
    bit seen;
    do_reset(32'h0000_0100, 3);
    inst_take = 1'b1;
    tick();
    total++; if (count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL empty_pop got=%0d/%b want=0/0", count, inst_valid); end
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (imem_req && imem_addr == 32'h10C) found = 1'b1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("FAIL rdw_find got=timeout want=req@10C"); end
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    total++; if (count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_flush got=%0d/%b want=0/0", count, inst_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin bad++; $display("FAIL rdw_hold got=%b/%h want=1/10C", imem_req, imem_addr); end
    got_ack = 1'b0;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      tick();
      if (imem_ack) begin
        got_ack = 1'b1;
        total++; if (imem_addr !== 32'h200 || inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_target got=%h/%b want=200/0", imem_addr, inst_valid); end
      end else begin
        total++; if (imem_addr !== 32'h10C || inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_held got=%h/%b want=10C/0", imem_addr, inst_valid); end
      end
    end
    total++; if (!got_ack) begin bad++; $display("FAIL rdw_ack got=timeout want=ack"); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (inst_valid) seen = 1'b1;
    end
    total++; if (!seen || inst_pc !== 32'h200 || inst_data !== mem_word(32'h200)) begin
      bad++; $display("FAIL rdw_first got=%b/%h/%h want=1/200/%h", seen, inst_pc, inst_data, mem_word(32'h200));
    end
    inst_take = 1'b0;
  endtask

  task automatic test_redirect_ack();
    do_reset(32'h0000_0100, 0);
    tick(); tick(); tick();
    total++; if (count !== 3'd2 || imem_addr !== 32'h108) begin bad++; $display("FAIL rda_setup got=%0d/%h want=2/108", count, imem_addr); end
    inst_take = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    total++; if (imem_ack !== 1'b1 || count !== 3'd0 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL rda_flush got=ack%b/%0d/%b want=1/0/0", imem_ack, count, inst_valid);
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL rda_next got=%b/%h want=1/200", imem_req, imem_addr); end
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || count !== 3'd1) begin
      bad++; $display("FAIL rda_first got=%b/%h/%0d want=1/200/1", inst_valid, inst_pc, count);
    end
    tick();
    total++; if (inst_pc !== 32'h204 || count !== 3'd1) begin bad++; $display("FAIL rda_second got=%h/%0d want=204/1", inst_pc, count); end
    inst_take = 1'b0;
  endtask

  task automatic test_reset_in_discard();
    bit ok;
    bit seen;
    do_reset(32'h0000_0100, 2);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (count == 3'd3) ok = 1'b1;
    end
    total++; if (!ok || imem_req !== 1'b1 || imem_addr !== 32'h10C) begin
      bad++; $display("FAIL rid_fill got=%b/%0d/%b/%h want=1/3/1/10C", ok, count, imem_req, imem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    total++; if (count !== 3'd0 || imem_addr !== 32'h10C || imem_req !== 1'b1) begin
      bad++; $display("FAIL rid_discard got=%0d/%h/%b want=0/10C/1", count, imem_addr, imem_req);
    end
    Rst = 1'b1; startPC = 32'h300;
    tick();
    Rst = 1'b0;
    total++; if (count !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL rid_reset got=%0d/%b/%b want=0/0/0", count, inst_valid, imem_req);
    end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin bad++; $display("FAIL rid_restart got=%b/%h want=1/300", imem_req, imem_addr); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (inst_valid) seen = 1'b1;
    end
    total++; if (!seen || inst_pc !== 32'h300 || inst_data !== mem_word(32'h300)) begin
      bad++; $display("FAIL rid_first got=%b/%h/%h want=1/300/%h", seen, inst_pc, inst_data, mem_word(32'h300));
    end
  endtask

  task automatic test_pc_wrap();
    do_reset(32'hFFFF_FFF8, 0);
    inst_take = 1'b1;
    tick(); tick();
    total++; if (inst_pc !== 32'hFFFF_FFF8 || inst_pc_plus4 !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap0 got=%h/%h want=FFFFFFF8/FFFFFFFC", inst_pc, inst_pc_plus4);
    end
    tick();
    total++; if (inst_pc !== 32'hFFFF_FFFC || inst_pc_plus4 !== 32'h0) begin
      bad++; $display("FAIL wrap1 got=%h/%h want=FFFFFFFC/0", inst_pc, inst_pc_plus4);
    end
    tick();
    total++; if (inst_pc !== 32'h0 || inst_pc_plus4 !== 32'h4 || inst_data !== mem_word(32'h0)) begin
      bad++; $display("FAIL wrap2 got=%h/%h/%h want=0/4/%h", inst_pc, inst_pc_plus4, inst_data, mem_word(32'h0));
    end
    inst_take = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_back_to_back();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_in_discard();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
